crossy_game_ctrl: RTL

- Game-level sequencer for the crossy-road VGA game. Sits between the raw button, the VGA frame timing and the obstacle/score datapath.
- Debounces the move button and issues single-cycle move pulses. Latches pixel-level chicken/obstacle collisions once per frame.
- Runs an ATTRACT/PLAY/DYING/OVER state machine. Drives datapath reset, freeze and chicken-flash, and tracks speed level and high score.

---
 rtl/crossy_game_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/crossy_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : crossy_game_ctrl
// Brief    : Crossy-road game sequencer: button debounce, per-frame collision
//            latch, ATTRACT/PLAY/DYING/OVER control, speed level, high score.
// Revision : 1.0  initial release
// ============================================================================
module crossy_game_ctrl #(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int DYING_FRAMES    = 64,
  parameter int FLASH_BIT       = 3,
  parameter int LVL1            = 10,
  parameter int LVL2            = 25,
  parameter int LVL3            = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_move_btn,
  input  logic       i_collision,
  input  logic [6:0] i_score,
  output logic       o_play_rst,
  output logic       o_freeze,
  output logic       o_move_pulse,
  output logic       o_flash,
  output logic [1:0] o_state,
  output logic [1:0] o_speed_level,
  output logic [6:0] o_high_score
);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_DYING   = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam logic [3:0] c_db_last = 4'(DEBOUNCE_FRAMES - 1);
  localparam logic [7:0] c_dy_last = 8'(DYING_FRAMES - 1);
  localparam logic [6:0] c_lvl1    = 7'(LVL1);
  localparam logic [6:0] c_lvl2    = 7'(LVL2);
  localparam logic [6:0] c_lvl3    = 7'(LVL3);

  state_t     r_state;
  logic       r_sync1;
  logic       r_sync2;
  logic       r_db_level;
  logic [3:0] r_db_cnt;
  logic       r_hit;
  logic [7:0] r_dy_cnt;

  logic       w_db_mismatch;
  logic       w_db_flip;
  logic       w_btn_evt;
  logic       w_play_hit;
  logic [7:0] w_dy_next;
  logic [1:0] w_level;

  assign w_db_mismatch = (r_sync2 != r_db_level);
  assign w_db_flip     = i_frame_tick && w_db_mismatch && (r_db_cnt == c_db_last);
  assign w_btn_evt     = w_db_flip && r_sync2;
  // A collision on the tick cycle itself still belongs to the frame being closed.
  assign w_play_hit    = (r_state == ST_PLAY) && i_frame_tick && (r_hit || i_collision);
  assign w_dy_next     = r_dy_cnt + 8'd1;
  assign o_state       = r_state;

  always_comb begin
    w_level = 2'd0;
    if (i_score >= c_lvl3)      w_level = 2'd3;
    else if (i_score >= c_lvl2) w_level = 2'd2;
    else if (i_score >= c_lvl1) w_level = 2'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= 4'd0;
    end else begin
      r_sync1 <= i_move_btn;
      r_sync2 <= r_sync1;
      if (i_frame_tick) begin
        if (w_db_flip) begin
          r_db_level <= r_sync2;
          r_db_cnt   <= 4'd0;
        end else if (w_db_mismatch) begin
          r_db_cnt <= r_db_cnt + 4'd1;
        end else begin
          r_db_cnt <= 4'd0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit <= 1'b0;
    end else if ((r_state != ST_PLAY) || i_frame_tick) begin
      r_hit <= 1'b0;
    end else if (i_collision) begin
      r_hit <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_ATTRACT;
      r_dy_cnt      <= 8'd0;
      o_play_rst    <= 1'b1;
      o_freeze      <= 1'b1;
      o_move_pulse  <= 1'b0;
      o_flash       <= 1'b0;
      o_speed_level <= 2'd0;
      o_high_score  <= 7'd0;
    end else begin
      o_move_pulse <= 1'b0;
      if (o_play_rst) o_speed_level <= 2'd0;

      case (r_state)
        ST_ATTRACT: begin
          o_play_rst <= 1'b1;
          o_freeze   <= 1'b1;
          o_flash    <= 1'b0;
          if (w_btn_evt) begin
            r_state    <= ST_PLAY;
            o_play_rst <= 1'b0;
            o_freeze   <= 1'b0;
          end
        end

        ST_PLAY: begin
          o_play_rst <= 1'b0;
          o_freeze   <= 1'b0;
          o_flash    <= 1'b0;
          if (i_frame_tick && !o_play_rst) o_speed_level <= w_level;
          if (w_play_hit) begin
            r_state  <= ST_DYING;
            r_dy_cnt <= 8'd0;
            o_freeze <= 1'b1;
            if (i_score > o_high_score) o_high_score <= i_score;
          end else if (w_btn_evt) begin
            o_move_pulse <= 1'b1;
          end
        end

        ST_DYING: begin
          o_play_rst <= 1'b0;
          o_freeze   <= 1'b1;
          if (i_frame_tick) begin
            if (r_dy_cnt == c_dy_last) begin
              r_state <= ST_OVER;
              o_flash <= 1'b0;
            end else begin
              r_dy_cnt <= w_dy_next;
              o_flash  <= w_dy_next[FLASH_BIT];
            end
          end
        end

        ST_OVER: begin
          o_freeze <= 1'b1;
          o_flash  <= 1'b0;
          // Restart pulses the datapath reset for the first PLAY cycle.
          if (w_btn_evt) begin
            r_state       <= ST_PLAY;
            o_play_rst    <= 1'b1;
            o_freeze      <= 1'b0;
            o_speed_level <= 2'd0;
          end
        end

        default: r_state <= ST_ATTRACT;
      endcase
    end
  end

endmodule
`default_nettype wire
